// File: rtl/set_bit_scanner16.sv
// Expands a captured mask word into a stream of set-bit indices, one per beat, plus any-set/popcount.
// Latency 1 cycle capture->first beat; stalls hold all outputs, in_ready only in IDLE (no overlap).
module set_bit_scanner16 #(
  parameter int WIDTH     = 16,
  parameter int IDX_W     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic             out_last,
  output logic             out_none,
  output logic             any_set,
  output logic [IDX_W:0]   pop_count
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             none_q, none_d;
  logic             any_q, any_d;
  logic [IDX_W:0]   pop_q, pop_d;

  logic [WIDTH-1:0] sel;
  logic [WIDTH-1:0] rest;
  logic [IDX_W-1:0] idx;
  logic [IDX_W:0]   pop_in;
  logic             single;
  logic             emitting;

  // Priority pick of the next bit; the last hit in loop order wins.
  always_comb begin
    idx = '0;
    sel = '0;
    if (LSB_FIRST) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (mask_q[i]) begin
          idx    = IDX_W'(i);
          sel    = '0;
          sel[i] = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (mask_q[i]) begin
          idx    = IDX_W'(i);
          sel    = '0;
          sel[i] = 1'b1;
        end
      end
    end
  end

  assign rest   = mask_q & ~sel;
  assign single = (|mask_q) & ~(|rest);

  always_comb begin
    pop_in = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop_in = pop_in + (IDX_W + 1)'(in_data[i]);
    end
  end

  assign emitting  = (state_q == EMIT);
  assign in_ready  = (state_q == IDLE);
  assign out_valid = emitting;
  assign out_index = emitting ? idx : '0;
  assign out_none  = emitting & none_q;
  assign out_last  = emitting & (none_q | single);
  assign any_set   = any_q;
  assign pop_count = pop_q;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    none_d  = none_q;
    any_d   = any_q;
    pop_d   = pop_q;
    case (state_q)
      IDLE: begin
        // in_data is only looked at on a handshake, so idle X never reaches state.
        if (in_valid) begin
          mask_d  = in_data;
          none_d  = ~(|in_data);
          any_d   = |in_data;
          pop_d   = pop_in;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          mask_d = rest;
          if (out_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mask_q  <= '0;
      none_q  <= 1'b0;
      any_q   <= 1'b0;
      pop_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      none_q  <= none_d;
      any_q   <= any_d;
      pop_q   <= pop_d;
    end
  end

endmodule

// File: tb/tb_set_bit_scanner16.sv
// Directed bench for set_bit_scanner16: LSB-first main instance plus an MSB-first instance.
module tb_set_bit_scanner16;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_index;
  logic        out_last;
  logic        out_none;
  logic        any_set;
  logic [4:0]  pop_count;

  logic        m_in_valid;
  logic        m_in_ready;
  logic [15:0] m_in_data;
  logic        m_out_valid;
  logic        m_out_ready;
  logic [3:0]  m_out_index;
  logic        m_out_last;
  logic        m_out_none;
  logic        m_any_set;
  logic [4:0]  m_pop_count;

  int total = 0;
  int bad   = 0;

  set_bit_scanner16 #(.WIDTH(16), .IDX_W(4), .LSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
    .out_last(out_last), .out_none(out_none),
    .any_set(any_set), .pop_count(pop_count)
  );

  set_bit_scanner16 #(.WIDTH(16), .IDX_W(4), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst_n(rst_n),
    .in_valid(m_in_valid), .in_ready(m_in_ready), .in_data(m_in_data),
    .out_valid(m_out_valid), .out_ready(m_out_ready), .out_index(m_out_index),
    .out_last(m_out_last), .out_none(m_out_none),
    .any_set(m_any_set), .pop_count(m_pop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    total++;
    if ({out_valid, out_index, out_last, out_none, any_set, pop_count} !== 13'd0) begin
      bad++;
      $display("FAIL reset_outputs: got vld=%b idx=%0d last=%b none=%b any=%b pop=%0d want all zero",
               out_valid, out_index, out_last, out_none, any_set, pop_count);
    end
    #10 rst_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic_8421();
    int exp_idx [4] = '{0, 5, 10, 15};
    step();
    in_valid  = 1'b1;
    in_data   = 16'h8421;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    in_data  = 16'hxxxx;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (out_valid !== 1'b1 || out_index !== 4'(exp_idx[k]) || out_last !== (k == 3) ||
          out_none !== 1'b0 || pop_count !== 5'd4 || any_set !== 1'b1 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL basic_8421 beat%0d: got vld=%b idx=%0d last=%b none=%b pop=%0d any=%b rdy=%b want 1 %0d %b 0 4 1 0",
                 k, out_valid, out_index, out_last, out_none, pop_count, any_set, in_ready, exp_idx[k], k == 3);
      end
      step();
    end
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || pop_count !== 5'd4 || any_set !== 1'b1) begin
      bad++;
      $display("FAIL basic_8421_idle: got vld=%b rdy=%b pop=%0d any=%b want 0 1 4 1",
               out_valid, in_ready, pop_count, any_set);
    end
  endtask

  task automatic test_zero_word();
    in_valid = 1'b1;
    in_data  = 16'h0000;
    step();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_none !== 1'b1 || out_last !== 1'b1 || out_index !== 4'd0 ||
        any_set !== 1'b0 || pop_count !== 5'd0) begin
      bad++;
      $display("FAIL zero_beat: got vld=%b none=%b last=%b idx=%0d any=%b pop=%0d want 1 1 1 0 0 0",
               out_valid, out_none, out_last, out_index, any_set, pop_count);
    end
    step();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_none !== 1'b0) begin
      bad++;
      $display("FAIL zero_done: got rdy=%b vld=%b none=%b want 1 0 0", in_ready, out_valid, out_none);
    end
  endtask

  task automatic test_full_stall();
    int errs = 0;
    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 32; c++) begin
      out_ready = (c % 2 == 1);
      total++;
      if (out_valid !== 1'b1 || out_index !== 4'(c / 2) || out_last !== (c / 2 == 15) ||
          pop_count !== 5'd16 || any_set !== 1'b1) begin
        bad++;
        errs++;
        if (errs < 4)
          $display("FAIL full_stall cyc%0d: got vld=%b idx=%0d last=%b pop=%0d any=%b want 1 %0d %b 16 1",
                   c, out_valid, out_index, out_last, pop_count, any_set, c / 2, c / 2 == 15);
      end
      step();
    end
    out_ready = 1'b1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL full_stall_end: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_msb_first();
    int exp_idx [3] = '{8, 2, 1};
    m_out_ready = 1'b1;
    m_in_valid  = 1'b1;
    m_in_data   = 16'h0106;
    step();
    m_in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (m_out_valid !== 1'b1 || m_out_index !== 4'(exp_idx[k]) || m_out_last !== (k == 2) ||
          m_pop_count !== 5'd3 || m_any_set !== 1'b1) begin
        bad++;
        $display("FAIL msb_first beat%0d: got vld=%b idx=%0d last=%b pop=%0d any=%b want 1 %0d %b 3 1",
                 k, m_out_valid, m_out_index, m_out_last, m_pop_count, m_any_set, exp_idx[k], k == 2);
      end
      step();
    end
    total++;
    if (m_out_valid !== 1'b0 || m_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL msb_first_end: got vld=%b rdy=%b want 0 1", m_out_valid, m_in_ready);
    end
  endtask

  task automatic test_reset_mid_burst();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'h00F0;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (out_valid !== 1'b1 || out_index !== 4'(4 + k)) begin
        bad++;
        $display("FAIL midrst_pre beat%0d: got vld=%b idx=%0d want 1 %0d", k, out_valid, out_index, 4 + k);
      end
      step();
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || pop_count !== 5'd0 || any_set !== 1'b0 || out_index !== 4'd0) begin
      bad++;
      $display("FAIL midrst_async: got vld=%b pop=%0d any=%b idx=%0d want 0 0 0 0",
               out_valid, pop_count, any_set, out_index);
    end
    #1 rst_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL midrst_release: got rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
    in_valid = 1'b1;
    in_data  = 16'h0001;
    step();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_index !== 4'd0 || out_last !== 1'b1 || pop_count !== 5'd1) begin
      bad++;
      $display("FAIL midrst_recapture: got vld=%b idx=%0d last=%b pop=%0d want 1 0 1 1",
               out_valid, out_index, out_last, pop_count);
    end
    step();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL midrst_tail: got vld=%b rdy=%b want 0 1 (stale beats after reset)", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] words [4] = '{16'h0003, 16'h0000, 16'h0003, 16'h0000};
    logic [9:0]  exp_rdy  = 10'b01_0010_1001;
    logic [9:0]  exp_last = 10'b10_1001_0100;
    logic [9:0]  exp_none = 10'b10_0001_0000;
    int          exp_idx [10] = '{0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
    int          capt = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int c = 0; c < 10; c++) begin
      total++;
      if (in_ready !== exp_rdy[c] || out_valid !== ~exp_rdy[c] || out_index !== 4'(exp_idx[c]) ||
          out_last !== exp_last[c] || out_none !== exp_none[c]) begin
        bad++;
        $display("FAIL back_to_back cyc%0d: got rdy=%b vld=%b idx=%0d last=%b none=%b want %b %b %0d %b %b",
                 c, in_ready, out_valid, out_index, out_last, out_none,
                 exp_rdy[c], ~exp_rdy[c], exp_idx[c], exp_last[c], exp_none[c]);
      end
      // Present the next word only when the block can take it; otherwise drive junk.
      if (in_ready && capt < 4) begin
        in_data = words[capt];
        capt++;
      end else begin
        in_data = 16'hFFFF;
      end
      if (capt == 4 && !in_ready) in_valid = 1'b0;
      step();
    end
    in_valid = 1'b0;
    step();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || any_set !== 1'b0) begin
      bad++;
      $display("FAIL back_to_back_end: got vld=%b rdy=%b any=%b want 0 1 0", out_valid, in_ready, any_set);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_data     = 16'h0000;
    out_ready   = 1'b0;
    m_in_valid  = 1'b0;
    m_in_data   = 16'h0000;
    m_out_ready = 1'b0;
    #3;
    test_reset();
    test_basic_8421();
    test_zero_word();
    test_full_stall();
    test_msb_first();
    test_reset_mid_burst();
    step();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
